// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one physical-memory cacheline port between the I-cache and the
//   D-cache. One requester is granted at a time and keeps the grant until
//   pmem_resp. Contention is resolved round-robin, and D wins the first
//   contention after reset. Saturating counters record completed
//   transactions for each requester.
//
// Ports
//   clk, rst                     clock; asynchronous active-low reset
//   i_read/i_addr                I-cache line read request
//   i_rdata/i_resp               I-cache response: broadcast data, 1-cycle pulse
//   d_read/d_write/d_addr/d_wdata D-cache read or writeback request
//   d_rdata/d_resp               D-cache response: broadcast data, 1-cycle pulse
//   pmem_*                       physical memory port
//   i_grant_cnt/d_grant_cnt      completed-transaction counters (saturating)
module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_last_d;
    logic [CNT_W-1:0] r_i_cnt;
    logic [CNT_W-1:0] r_d_cnt;

    logic w_d_req;
    logic w_i_resp;
    logic w_d_resp;

    assign w_d_req  = d_read | d_write;
    // A response that arrives in IDLE is stale, so it is not forwarded.
    assign w_i_resp = pmem_resp && (r_state == SERVE_I);
    assign w_d_resp = pmem_resp && (r_state == SERVE_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_i_cnt  <= '0;
            r_d_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // D goes first unless it was the last requester served
                    // and I is also waiting.
                    if (w_d_req && (!i_read || !r_last_d)) begin
                        r_state <= SERVE_D;
                    end else if (i_read) begin
                        r_state <= SERVE_I;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        r_state  <= IDLE;
                        r_last_d <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        r_state  <= IDLE;
                        r_last_d <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_i_resp && (r_i_cnt != '1)) begin
                r_i_cnt <= r_i_cnt + CNT_ONE;
            end
            if (w_d_resp && (r_d_cnt != '1)) begin
                r_d_cnt <= r_d_cnt + CNT_ONE;
            end
        end
    end

    // The memory port follows the live inputs of whichever requester holds
    // the grant.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        case (r_state)
            SERVE_I: begin
                pmem_read = i_read;
                pmem_addr = i_addr;
            end
            SERVE_D: begin
                // If read and write are both raised, only the write is issued.
                pmem_read  = d_read & ~d_write;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    // Read data goes to both caches. It is forced to zero while reset is held.
    assign i_rdata     = rst ? pmem_rdata : '0;
    assign d_rdata     = rst ? pmem_rdata : '0;
    assign i_resp      = w_i_resp;
    assign d_resp      = w_d_resp;
    assign i_grant_cnt = r_i_cnt;
    assign d_grant_cnt = r_d_cnt;

    // The D-cache must never raise read and write together.
    assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Directed bench for cache_arbiter. The responses each cache should see
//   are queued in the order grants should occur. A negedge monitor pops the
//   queue whenever i_resp or d_resp fires. A second instance with a 2-bit
//   counter width shares all inputs and is used for the saturation case.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    typedef struct {
        bit            is_d;
        logic [LW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [31:0]   i_cnt, d_cnt;

    logic [LW-1:0] i_rdata2, d_rdata2, pmem_wdata2;
    logic          i_resp2, d_resp2, pmem_read2, pmem_write2;
    logic [AW-1:0] pmem_addr2;
    logic [1:0]    i_cnt2, d_cnt2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_cnt(i_cnt), .d_grant_cnt(d_cnt)
    );

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata2), .i_resp(i_resp2),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata2), .d_resp(d_resp2),
        .pmem_read(pmem_read2), .pmem_write(pmem_write2), .pmem_addr(pmem_addr2),
        .pmem_wdata(pmem_wdata2), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_cnt(i_cnt2), .d_grant_cnt(d_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every response against the head of the expected-response queue.
    always @(negedge clk) begin
        if (i_resp) begin
            check("i_resp_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("i_resp_who", sb[0].is_d, 1'b0);
                check("i_rdata", i_rdata, sb[0].data);
                void'(sb.pop_front());
            end
        end
        if (d_resp) begin
            check("d_resp_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                check("d_resp_who", sb[0].is_d, 1'b1);
                check("d_rdata", d_rdata, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    // Memory model for one transaction. It waits (bounded) for a request,
    // checks the request fields, then pulses resp after lat cycles. It drops
    // the chosen requests in the following idle cycle, where it checks that
    // the port is quiet.
    task automatic mem_txn(input string tag, input int lat, input logic [LW-1:0] data,
                           input logic exp_rd, input logic exp_wr,
                           input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                           input bit drop_i, input bit drop_d, output int waited);
        waited = 0;
        while (waited < 50) begin
            @(negedge clk);
            waited++;
            if (pmem_read || pmem_write) break;
        end
        check({tag, "_grant"}, (pmem_read || pmem_write), 1);
        if (!(pmem_read || pmem_write)) return;
        check({tag, "_rd"}, pmem_read, exp_rd);
        check({tag, "_wr"}, pmem_write, exp_wr);
        check({tag, "_addr"}, pmem_addr, exp_addr);
        check({tag, "_wdata"}, pmem_wdata, exp_wdata);
        repeat (lat) @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (drop_i) i_read = 1'b0;
        if (drop_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(negedge clk);
        check({tag, "_turnaround_idle"}, {pmem_read, pmem_write}, 2'b00);
    endtask

    task automatic do_reset();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        #1 rst = 1'b0;
        tick();
        check("reset_cnt", {i_cnt, d_cnt, i_cnt2, d_cnt2}, 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stim
        int w;
        logic [LW-1:0] dw, di, wd;

        // Hold reset with random inputs: every output must stay zero.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            i_read     = 1'($urandom);
            i_addr     = $urandom;
            d_read     = 1'($urandom);
            d_write    = 1'($urandom);
            d_addr     = $urandom;
            d_wdata    = rand_line();
            pmem_rdata = rand_line();
            pmem_resp  = 1'($urandom);
            @(negedge clk);
            check("rst_ctrl", {i_resp, d_resp, pmem_read, pmem_write, pmem_addr,
                               i_resp2, d_resp2, pmem_read2, pmem_write2, pmem_addr2}, 0);
            check("rst_rdata", i_rdata | d_rdata | i_rdata2 | d_rdata2, 0);
            check("rst_wdata", pmem_wdata | pmem_wdata2, 0);
            check("rst_cnt", {i_cnt, d_cnt, i_cnt2, d_cnt2}, 0);
        end
        tick();
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; pmem_rdata = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_no_req", {pmem_read, pmem_write, pmem_addr}, 0);
        end

        // A lone I-cache read.
        tick();
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        di = {32{8'hA5}};
        sb.push_back('{1'b0, di});
        mem_txn("ionly", 5, di, 1'b1, 1'b0, 32'h60, '0, 1'b1, 1'b0, w);
        check("ionly_latency", w, 2);
        check("ionly_cnt", {i_cnt, d_cnt}, {32'd1, 32'd0});

        // I and D request together after reset: D is served first.
        do_reset();
        tick();
        dw = rand_line();
        di = rand_line();
        wd = rand_line();
        i_read  = 1'b1;
        i_addr  = 32'h0000_0100;
        d_write = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = wd;
        sb.push_back('{1'b1, dw});
        sb.push_back('{1'b0, di});
        mem_txn("cont_d", 3, dw, 1'b0, 1'b1, 32'h2000, wd, 1'b0, 1'b1, w);
        check("cont_d_latency", w, 2);
        mem_txn("cont_i", 2, di, 1'b1, 1'b0, 32'h100, '0, 1'b1, 1'b0, w);
        check("cont_i_latency", w, 1);
        check("cont_cnt", {i_cnt, d_cnt}, {32'd1, 32'd1});

        // Both requesters keep requesting: grants alternate D,I,D,I,...
        do_reset();
        tick();
        i_read  = 1'b1;
        i_addr  = 32'h0000_0040;
        d_read  = 1'b1;
        d_addr  = 32'h0000_0080;
        d_wdata = '0;
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{(k % 2 == 0), {8{32'hC0DE_0000 + 32'(k)}}});
        end
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                mem_txn("rr_d", 1 + k % 3, {8{32'hC0DE_0000 + 32'(k)}}, 1'b1, 1'b0,
                        32'h80, '0, (k == 7), (k == 7), w);
            else
                mem_txn("rr_i", 1 + k % 3, {8{32'hC0DE_0000 + 32'(k)}}, 1'b1, 1'b0,
                        32'h40, '0, (k == 7), (k == 7), w);
            check("rr_latency", w, (k == 0) ? 2 : 1);
        end
        check("rr_cnt", {i_cnt, d_cnt}, {32'd4, 32'd4});

        // Reset during SERVE_D. A later pmem_resp must be ignored.
        do_reset();
        tick();
        d_read = 1'b1;
        d_addr = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        check("mr_grant", {pmem_read, pmem_addr}, {1'b1, 32'h300});
        #1 rst = 1'b0;
        #1;
        check("mr_async_pmem", {pmem_read, pmem_write, pmem_addr}, 0);
        d_read = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        @(negedge clk);
        check("mr_stale_resp", {i_resp, d_resp}, 2'b00);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        check("mr_stays_idle", {pmem_read, pmem_write}, 2'b00);
        check("mr_cnt", {i_cnt, d_cnt}, 0);

        // With a 2-bit counter, the I count saturates at 3.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            tick();
            i_read = 1'b1;
            i_addr = 32'h0000_1000 + 32'(t) * 32'h20;
            di = rand_line();
            sb.push_back('{1'b0, di});
            mem_txn("sat", 2, di, 1'b1, 1'b0, 32'h0000_1000 + 32'(t) * 32'h20, '0,
                    1'b1, 1'b0, w);
            check("sat_cnt2", i_cnt2, (t < 3) ? t + 1 : 3);
            check("sat_cnt32", i_cnt, t + 1);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
